// File: rtl/alu_chk_pkg.sv
// Shared definitions for the ALU start/done handshake checker.
//   NUM_CHECKS  - number of protocol checks (width of pulse/sticky/enable)
//   check_id_e  - bit index of each check in the pulse/sticky/enable vectors
//   chk_state_e - handshake tracking state
package alu_chk_pkg;
    localparam int NUM_CHECKS = 5;

    typedef enum logic [2:0] {
        STABLE  = 3'd0,
        CLEAR   = 3'd1,
        ORPHAN  = 3'd2,
        DROP    = 3'd3,
        TIMEOUT = 3'd4
    } check_id_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        POST   = 2'd2
    } chk_state_e;
endpackage

// File: rtl/chk_err_accum.sv
// Generic error accumulator for protocol checkers: masks raw check fires,
// registers them as one-cycle pulses, keeps sticky flags and a saturating
// count of fired checks.
//   clk, reset : clock, synchronous active-high reset
//   raw_i      : unmasked check fires sampled this cycle
//   en_i       : per-check enable mask
//   clear_i    : clears sticky flags and count (this cycle's fires still land)
//   pulse_o    : registered masked fires
//   sticky_o   : OR of all pulses since reset/clear
//   count_o    : saturating number of pulses since reset/clear
module chk_err_accum #(
    parameter int NUM   = 5,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NUM-1:0]   raw_i,
    input  logic [NUM-1:0]   en_i,
    input  logic             clear_i,
    output logic [NUM-1:0]   pulse_o,
    output logic [NUM-1:0]   sticky_o,
    output logic [CNT_W-1:0] count_o
);
    // Wide enough to hold a saturated count plus every check firing at once.
    localparam int SUM_W = CNT_W + $clog2(NUM + 1);
    localparam logic [SUM_W-1:0] SAT = SUM_W'({CNT_W{1'b1}});

    logic [NUM-1:0]   pulse_d,  pulse_q;
    logic [NUM-1:0]   sticky_d, sticky_q;
    logic [CNT_W-1:0] count_d,  count_q;
    logic [SUM_W-1:0] sum;

    always_comb begin
        pulse_d  = raw_i & en_i;
        // clear wipes history first, then this cycle's pulses are recorded
        sticky_d = (clear_i ? '0 : sticky_q) | pulse_d;
        sum      = clear_i ? '0 : SUM_W'(count_q);
        for (int i = 0; i < NUM; i++) begin
            sum = sum + SUM_W'(pulse_d[i]);
        end
        count_d  = (sum > SAT) ? SAT[CNT_W-1:0] : sum[CNT_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pulse_q  <= '0;
            sticky_q <= '0;
            count_q  <= '0;
        end else begin
            pulse_q  <= pulse_d;
            sticky_q <= sticky_d;
            count_q  <= count_d;
        end
    end

    assign pulse_o  = pulse_q;
    assign sticky_o = sticky_q;
    assign count_o  = count_q;
endmodule

// File: rtl/alu_handshake_checker.sv
// Protocol monitor for the ALU start/done handshake. Tracks each request,
// flags operand instability, missing clear after done, orphan done, early
// start withdrawal and latency overrun, and reports transaction statistics.
//   clk, reset            : clock, synchronous active-high reset
//   start, done           : ALU handshake
//   op, A, B              : request payload, must hold while a request is open
//   check_en              : per-check enable mask (index = check_id_e)
//   clear                 : clears err_sticky / err_count
//   err_pulse/err_sticky  : per-check registered pulse / accumulated flags
//   err_count             : saturating count of fired checks
//   txn_count             : completed transactions (wraps)
//   last_lat              : latency of the last completed transaction
//   busy                  : request open
module alu_handshake_checker
    import alu_chk_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int OP_W    = 3,
    parameter int MAX_LAT = 16,
    parameter int CNT_W   = 8
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    input  logic                           done,
    input  logic [OP_W-1:0]                op,
    input  logic [DATA_W-1:0]              A,
    input  logic [DATA_W-1:0]              B,
    input  logic [NUM_CHECKS-1:0]          check_en,
    input  logic                           clear,
    output logic [NUM_CHECKS-1:0]          err_pulse,
    output logic [NUM_CHECKS-1:0]          err_sticky,
    output logic [CNT_W-1:0]               err_count,
    output logic [CNT_W-1:0]               txn_count,
    output logic [$clog2(MAX_LAT+1)-1:0]   last_lat,
    output logic                           busy
);
    localparam int LAT_W = $clog2(MAX_LAT + 1);
    localparam int REQ_W = OP_W + 2 * DATA_W;
    localparam logic [LAT_W-1:0] LAT_MAX = LAT_W'(MAX_LAT);

    chk_state_e        state_q, state_d;
    logic [REQ_W-1:0]  req_q, req_d, req_now;
    logic [LAT_W-1:0]  lat_q, lat_d, lat_inc;
    logic [LAT_W-1:0]  last_lat_q, last_lat_d;
    logic [CNT_W-1:0]  txn_q, txn_d;
    logic              stab_q, stab_d;   // STABLE already fired this request
    logic              to_q, to_d;       // TIMEOUT already fired this request
    logic [NUM_CHECKS-1:0] raw;

    assign req_now = {op, A, B};
    // Latency advances before any decision in ACTIVE, saturating at MAX_LAT.
    assign lat_inc = (lat_q == LAT_MAX) ? lat_q : lat_q + LAT_W'(1);

    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        lat_d      = lat_q;
        last_lat_d = last_lat_q;
        txn_d      = txn_q;
        stab_d     = stab_q;
        to_d       = to_q;
        raw        = '0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    req_d  = req_now;
                    lat_d  = '0;
                    stab_d = 1'b0;
                    to_d   = 1'b0;
                    if (done) begin
                        txn_d      = txn_q + CNT_W'(1);
                        last_lat_d = '0;
                        state_d    = POST;
                    end else begin
                        state_d = ACTIVE;
                    end
                end else if (done) begin
                    raw[ORPHAN] = 1'b1;
                end
            end
            ACTIVE: begin
                lat_d = lat_inc;
                if (req_now != req_q && !stab_q) begin
                    raw[STABLE] = 1'b1;
                    stab_d      = 1'b1;
                end
                if (done) begin
                    // done completes the transaction even if start already fell
                    raw[ORPHAN] = ~start;
                    txn_d       = txn_q + CNT_W'(1);
                    last_lat_d  = lat_inc;
                    state_d     = POST;
                end else if (!start) begin
                    raw[DROP] = 1'b1;
                    state_d   = IDLE;
                end else if (lat_inc == LAT_MAX && !to_q) begin
                    raw[TIMEOUT] = 1'b1;
                    to_d         = 1'b1;
                end
            end
            POST: begin
                raw[CLEAR] = start | done;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            req_q      <= '0;
            lat_q      <= '0;
            last_lat_q <= '0;
            txn_q      <= '0;
            stab_q     <= 1'b0;
            to_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            lat_q      <= lat_d;
            last_lat_q <= last_lat_d;
            txn_q      <= txn_d;
            stab_q     <= stab_d;
            to_q       <= to_d;
        end
    end

    chk_err_accum #(
        .NUM   (NUM_CHECKS),
        .CNT_W (CNT_W)
    ) u_accum (
        .clk      (clk),
        .reset    (reset),
        .raw_i    (raw),
        .en_i     (check_en),
        .clear_i  (clear),
        .pulse_o  (err_pulse),
        .sticky_o (err_sticky),
        .count_o  (err_count)
    );

    assign txn_count = txn_q;
    assign last_lat  = last_lat_q;
    assign busy      = (state_q == ACTIVE);
endmodule
